inst_sequencer: RTL and testbench

Instruction sequencer feeding the `inst` input of the PE-array `control` decoder. Holds a small program of 64-bit PE instructions written by the host, then replays it on command, optionally looping a fixed number of times, presenting one registered instruction per cycle. When idle or held, it drives the all-zero instruction, which `control` decodes as LOAD with zeroed DSP modes.

---
 rtl/inst_sequencer_pkg.sv | 18 +
 rtl/inst_sequencer_if.sv | 31 +++
 rtl/inst_sequencer_mem.sv | 24 ++
 rtl/inst_sequencer.sv | 130 +++++++++++++
 tb/tb_inst_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared constants and FSM encoding for the PE-array instruction sequencer.
package inst_sequencer_pkg;

  localparam int SEQ_INST_WIDTH = 64;
  localparam int SEQ_DEPTH      = 16;
  localparam int SEQ_ADDR_WIDTH = 4;
  localparam int SEQ_ITER_WIDTH = 8;

  // All-zero instruction; control decodes it as LOAD with zeroed DSP modes.
  localparam logic [SEQ_INST_WIDTH-1:0] INST_NOP = '0;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/inst_sequencer_if.sv
// Host-side program/command bus and instruction output of the sequencer.
interface inst_sequencer_if
  import inst_sequencer_pkg::*;
#(
  parameter int INST_WIDTH = SEQ_INST_WIDTH,
  parameter int DEPTH      = SEQ_DEPTH,
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int ITER_WIDTH = SEQ_ITER_WIDTH
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [INST_WIDTH-1:0] wr_inst;
  logic                  start;
  logic [ADDR_WIDTH:0]   prog_len;
  logic [ITER_WIDTH-1:0] iter;
  logic                  hold;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output wr_en, wr_addr, wr_inst, start, prog_len, iter, hold,
    input  inst, inst_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_inst, start, prog_len, iter, hold,
    output inst, inst_valid, busy, done
  );
endinterface

// File: rtl/inst_sequencer_mem.sv
// Program store: DEPTH x INST_WIDTH register file, synchronous write,
// asynchronous read (maps to distributed RAM). Contents are not reset.
module inst_mem #(
  parameter int INST_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [INST_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [INST_WIDTH-1:0] o_rd_data
);
  logic [INST_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/inst_sequencer.sv
// Replays a host-written program of PE instructions, optionally looping,
// one registered instruction per cycle; drives NOP whenever not issuing.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int INST_WIDTH = SEQ_INST_WIDTH,
  parameter int DEPTH      = SEQ_DEPTH,
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int ITER_WIDTH = SEQ_ITER_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_sequencer_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);

  seq_state_t            r_state;
  seq_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_pass;
  logic [INST_WIDTH-1:0] r_inst;
  logic                  r_inst_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [INST_WIDTH-1:0] w_rd_data;
  logic [ADDR_WIDTH:0]   w_len_clamped;
  logic                  w_pc_last;
  logic                  w_pass_last;
  logic                  w_issue;
  logic                  w_mem_we;

  assign w_len_clamped = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
  assign w_pc_last     = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_pass_last   = (r_pass == (r_iter - 1'b1));
  // The program is frozen outside IDLE, including during a replay.
  assign w_mem_we      = bus.wr_en && (r_state == SEQ_IDLE);

  inst_mem #(
    .INST_WIDTH (INST_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_inst_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_inst),
    .i_rd_addr (r_pc),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (bus.start) begin
          if (w_len_clamped == '0 || bus.iter == '0) begin
            w_state_next = SEQ_FIN;
          end else begin
            w_state_next = SEQ_RUN;
          end
        end
      end
      SEQ_RUN: begin
        if (!bus.hold) begin
          w_issue = 1'b1;
          if (w_pc_last && w_pass_last) begin
            w_state_next = SEQ_FIN;
          end
        end
      end
      SEQ_FIN: w_state_next = SEQ_IDLE;
      default: w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= '0;
      r_len        <= '0;
      r_iter       <= '0;
      r_pass       <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_done       <= (r_state == SEQ_FIN);
      // Covers the RUN entry edge and the final issue edge, so busy rises
      // with the start and falls together with the done pulse.
      r_busy       <= (r_state == SEQ_RUN) || (w_state_next == SEQ_RUN);
      if (r_state == SEQ_IDLE && bus.start) begin
        r_len  <= w_len_clamped;
        r_iter <= bus.iter;
        r_pc   <= '0;
        r_pass <= '0;
      end
      if (w_issue) begin
        r_inst       <= w_rd_data;
        r_inst_valid <= 1'b1;
        if (w_pc_last) begin
          if (!w_pass_last) begin
            r_pc   <= '0;
            r_pass <= r_pass + 1'b1;
          end
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_inst_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: expected instructions are queued at
// start and popped by a monitor whenever inst_valid is seen.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] model_mem [16];
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;
  bit          mon_en = 1'b0;

  inst_sequencer_if #(
    .INST_WIDTH (64),
    .DEPTH      (16),
    .ADDR_WIDTH (4),
    .ITER_WIDTH (8)
  ) bus ();

  inst_sequencer #(
    .INST_WIDTH (64),
    .DEPTH      (16),
    .ADDR_WIDTH (4),
    .ITER_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.inst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", bus.inst, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("inst", bus.inst, mon_exp);
        end
      end else begin
        check_eq("nop_when_invalid", bus.inst, INST_NOP);
      end
    end
  end

  task automatic write_mem(input logic [3:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_inst = data;
    model_mem[addr] = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic run_prog(input string name, input int len_in, input int it,
                          input int hold_after, input int hold_len, input int inj_at,
                          input bit sw_en, input logic [3:0] sw_addr, input logic [63:0] sw_data);
    int eff_len, total, exp_done, cyc, nv, hrem;
    bit hstarted, seen_done, prev_busy;
    eff_len   = (len_in > 16) ? 16 : len_in;
    total     = eff_len * it;
    cyc = 0; nv = 0; hrem = 0;
    hstarted = 1'b0; seen_done = 1'b0; prev_busy = 1'b0;
    exp_done = (total == 0) ? 2 :
               total + ((hold_after > 0 && hold_after < total) ? hold_len : 0) + 2;
    @(negedge clk);
    if (sw_en) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = sw_addr;
      bus.wr_inst = sw_data;
      model_mem[sw_addr] = sw_data;
    end
    for (int p = 0; p < it; p++)
      for (int i = 0; i < eff_len; i++)
        exp_q.push_back(model_mem[i]);
    bus.start    = 1'b1;
    bus.prog_len = 5'(len_in);
    bus.iter     = 8'(it);
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (cyc == 1) check_eq({name, "_busy_after_start"}, 64'(bus.busy), 64'(total != 0));
      if (bus.inst_valid === 1'b1) nv++;
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        check_eq({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
        check_eq({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        if (total != 0) check_eq({name, "_busy_before_done"}, 64'(prev_busy), 64'd1);
      end
      prev_busy = bus.busy;
      if (!hstarted && hold_after > 0 && nv == hold_after) begin
        hstarted = 1'b1;
        hrem     = hold_len;
      end
      if (hrem > 0) begin
        bus.hold = 1'b1;
        hrem--;
      end else begin
        bus.hold = 1'b0;
      end
      if (inj_at > 0 && cyc == inj_at) begin
        bus.start    = 1'b1;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd5;
        bus.wr_inst  = 64'hABCD;
        bus.prog_len = 5'd16;
        bus.iter     = 8'd3;
      end
    end
    bus.hold = 1'b0;
    if (!seen_done) check_eq({name, "_done_timeout"}, 64'd0, 64'd1);
    check_eq({name, "_valid_count"}, 64'(nv), 64'(total));
    @(negedge clk);
    check_eq({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    check_eq({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_inst = '0;
    bus.start = 1'b0; bus.prog_len = '0; bus.iter = '0; bus.hold = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_inst",  bus.inst, 64'd0);
    check_eq("reset_valid", 64'(bus.inst_valid), 64'd0);
    check_eq("reset_busy",  64'(bus.busy), 64'd0);
    check_eq("reset_done",  64'(bus.done), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) write_mem(4'(i), {$urandom, $urandom});
    write_mem(4'd0, 64'h0100_0000_0000_0000);
    write_mem(4'd1, 64'h0000_0000_0300_0000);
    write_mem(4'd2, 64'h0000_0000_0700_0000);

    run_prog("basic",    3,   1, 0, 0, 0, 1'b0, 4'd0, 64'd0);
    run_prog("loop2",    3,   2, 0, 0, 0, 1'b0, 4'd0, 64'd0);
    run_prog("hold",     3,   1, 2, 2, 0, 1'b0, 4'd0, 64'd0);
    run_prog("len0",     0,   1, 0, 0, 0, 1'b0, 4'd0, 64'd0);
    run_prog("iter0",    3,   0, 0, 0, 0, 1'b0, 4'd0, 64'd0);
    run_prog("clamp",    20,  1, 0, 0, 0, 1'b0, 4'd0, 64'd0);
    run_prog("fullmax",  16,  3, 5, 1, 0, 1'b0, 4'd0, 64'd0);
    run_prog("inject",   6,   1, 0, 0, 2, 1'b0, 4'd0, 64'd0);
    run_prog("readback", 6,   1, 0, 0, 0, 1'b0, 4'd0, 64'd0);
    run_prog("samecyc",  2,   1, 0, 0, 0, 1'b1, 4'd1, 64'h1234_5678_9ABC_DEF0);
    run_prog("iter255",  1, 255, 0, 0, 0, 1'b0, 4'd0, 64'd0);

    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        exp_q.push_back(model_mem[i]);
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = 5'd16; bus.iter = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrun_reset_inst",  bus.inst, 64'd0);
    check_eq("midrun_reset_valid", 64'(bus.inst_valid), 64'd0);
    check_eq("midrun_reset_busy",  64'(bus.busy), 64'd0);
    check_eq("midrun_reset_done",  64'(bus.done), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("no_done_after_abort", 64'(bus.done), 64'd0);
    end
    run_prog("post_reset", 5, 1, 0, 0, 0, 1'b0, 4'd0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
